// File: rtl/opb_reg_pkg.sv
// opb_reg_pkg: shared constants for the simulink2ppc snapshot register.
//   Word offsets (OPB_ABus[24:29]), STATUS/CTRL bit positions and the
//   bus-slave FSM state type. Bit positions are in little-endian [31:0]
//   numbering of the read word; OPB DBus[0] corresponds to bit 31.
package opb_reg_pkg;

  // Word indices, i.e. byte offset / 4
  localparam logic [5:0] OFS_DATA   = 6'd0;  // 0x00
  localparam logic [5:0] OFS_STATUS = 6'd1;  // 0x04
  localparam logic [5:0] OFS_CTRL   = 6'd2;  // 0x08
  localparam logic [5:0] OFS_TS     = 6'd3;  // 0x0C

  localparam int ST_NEW   = 31;  // DBus[0]
  localparam int ST_OVR   = 30;  // DBus[1]
  localparam int ST_FRZ   = 29;  // DBus[2]
  localparam int CTRL_FRZ = 0;   // DBus[31]

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

endpackage

// File: rtl/opb_slave_ack.sv
// opb_slave_ack: OPB hit decode, transfer FSM and ack/read-data gating.
//   clk, rst_n    : clock, async active-low reset
//   i_abus        : OPB byte address [0:31]
//   i_rnw         : 1 = read
//   i_select      : OPB_select
//   i_rd_data     : read word from the register file, valid during ack
//   o_ack         : one-cycle transfer acknowledge
//   o_word        : word offset latched at the hit
//   o_rnw         : direction latched at the hit
//   o_dbus        : i_rd_data during ack, zero otherwise
module opb_slave_ack
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0100_1100,
  parameter logic [31:0] HIGH = 32'h0110_11FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:31] i_abus,
  input  logic        i_rnw,
  input  logic        i_select,
  input  logic [31:0] i_rd_data,
  output logic        o_ack,
  output logic [5:0]  o_word,
  output logic        o_rnw,
  output logic [0:31] o_dbus
);

  state_t     r_state;
  logic       r_ack;
  logic [5:0] r_word;
  logic       r_rnw;
  logic       w_hit;

  assign w_hit = i_select && (i_abus >= BASE) && (i_abus <= HIGH);

  // Address and direction are latched at the hit so the ack-cycle decode
  // does not depend on the master keeping the bus stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_word  <= '0;
      r_rnw   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_hit) begin
          r_state <= ACK;
          r_ack   <= 1'b1;
          r_word  <= i_abus[24:29];
          r_rnw   <= i_rnw;
        end
        ACK: begin
          r_ack   <= 1'b0;
          // select already gone: skip HOLD so a new transfer can start
          r_state <= i_select ? HOLD : IDLE;
        end
        HOLD: if (!i_select) r_state <= IDLE;
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack  = r_ack;
  assign o_word = r_word;
  assign o_rnw  = r_rnw;
  assign o_dbus = r_ack ? i_rd_data : '0;

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// opb_register_simulink2ppc_snap: captures a fabric word on user_valid and
//   returns it to software over OPB, with update count, NEW/OVR flags and a
//   FREEZE control. Optional macro SIMULINK2PPC_TIMESTAMP_EN adds a free-
//   running cycle counter latched on each capture, readable at 0x0C.
//   OPB_*          : OPB slave bus inputs (OPB_seqAddr ignored)
//   Sl_*           : OPB slave responses (errAck/retry/toutSup tied 0)
//   user_data_in   : word to capture
//   user_valid     : capture strobe
module opb_register_simulink2ppc_snap
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_1100,
  parameter logic [31:0] C_HIGHADDR   = 32'h0110_11FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_valid
);

  logic [31:0] r_data;
  logic [15:0] r_cnt;
  logic        r_new, r_ovr, r_frz;
  logic [31:0] w_rdata;
  logic [5:0]  w_word;
  logic        w_rnw, w_ack;
  logic        w_cap, w_clr_new, w_clr_ovr, w_wr_ctrl;
  logic        w_unused;

  assign w_unused = ^{1'b0, OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:30]};

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  opb_slave_ack #(.BASE(C_BASEADDR), .HIGH(C_HIGHADDR)) u_ack (
    .clk       (OPB_Clk),
    .rst_n     (OPB_Rst_n),
    .i_abus    (OPB_ABus),
    .i_rnw     (OPB_RNW),
    .i_select  (OPB_select),
    .i_rd_data (w_rdata),
    .o_ack     (w_ack),
    .o_word    (w_word),
    .o_rnw     (w_rnw),
    .o_dbus    (Sl_DBus)
  );

  assign Sl_xferAck = w_ack;

  // Clears and CTRL writes land on the edge that ends the ack cycle.
  assign w_cap     = user_valid && !r_frz;
  assign w_clr_new = w_ack && w_rnw && (w_word == OFS_DATA);
  assign w_clr_ovr = w_ack && w_rnw && (w_word == OFS_STATUS);
  assign w_wr_ctrl = w_ack && !w_rnw && (w_word == OFS_CTRL) && OPB_BE[3];

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_new  <= 1'b0;
      r_ovr  <= 1'b0;
      r_frz  <= 1'b0;
    end else begin
      if (w_cap) begin
        r_data <= user_data_in;
        r_cnt  <= r_cnt + 16'd1;
      end
      // capture beats a DATA-read clear for NEW
      if (w_cap)          r_new <= 1'b1;
      else if (w_clr_new) r_new <= 1'b0;
      // any clear in the same cycle as a capture suppresses the overrun
      if (w_clr_ovr)                          r_ovr <= 1'b0;
      else if (w_cap && r_new && !w_clr_new)  r_ovr <= 1'b1;
      if (w_wr_ctrl) r_frz <= OPB_DBus[31];
    end
  end

`ifdef SIMULINK2PPC_TIMESTAMP_EN
  logic [31:0] r_tsc, r_ts;
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_tsc <= '0;
      r_ts  <= '0;
    end else begin
      r_tsc <= r_tsc + 32'd1;
      if (w_cap) r_ts <= r_tsc;
    end
  end
`endif

  always_comb begin
    w_rdata = '0;
    case (w_word)
      OFS_DATA: w_rdata = r_data;
      OFS_STATUS: begin
        w_rdata[ST_NEW] = r_new;
        w_rdata[ST_OVR] = r_ovr;
        w_rdata[ST_FRZ] = r_frz;
        w_rdata[15:0]   = r_cnt;
      end
      OFS_CTRL: w_rdata[CTRL_FRZ] = r_frz;
`ifdef SIMULINK2PPC_TIMESTAMP_EN
      OFS_TS: w_rdata = r_ts;
`endif
      default: w_rdata = '0;
    endcase
  end

endmodule
